adder_seq_ctrl: RTL and testbench



---
 rtl/adder_seq_ctrl_pkg.sv | 18 +
 rtl/adder_seq_ctrl_if.sv | 33 +++
 rtl/adder_seq_ctrl_adder.sv | 27 ++
 rtl/adder_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_adder_seq_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// slice width, controller states and the signed-overflow rule.
package adder_seq_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operands of equal sign whose sum flips sign have overflowed.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Request/response handshake bundle for adder_seq_ctrl; master is the
// requester/consumer, slave is the sequencer.
interface adder_seq_ctrl_if
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) ();

    localparam int W = SLICE_W * WORDS;

    logic         io_in_valid;
    logic         io_in_ready;
    logic [W-1:0] io_in_a;
    logic [W-1:0] io_in_b;
    logic         io_in_sub;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_out_sum;
    logic         io_out_cout;
    logic         io_out_ovf;
    logic         io_busy;

    modport master (
        output io_in_valid, io_in_a, io_in_b, io_in_sub, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_sum, io_out_cout, io_out_ovf, io_busy
    );

    modport slave (
        input  io_in_valid, io_in_a, io_in_b, io_in_sub, io_out_ready,
        output io_in_ready, io_out_valid, io_out_sum, io_out_cout, io_out_ovf, io_busy
    );

endinterface

// File: rtl/adder_seq_ctrl_adder.sv
// The existing 4-bit ripple-carry Adder core: purely combinational,
// one full adder per bit.
module adder_seq_ctrl_adder
    import adder_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] c;

    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < SLICE_W; gi++) begin : g_fa
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[SLICE_W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: streams WORDS 4-bit slices of the
// operands through one shared Adder core, LSB slice first, chaining carry.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic          clock,
    input  logic          reset,
    adder_seq_ctrl_if.slave io
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int NSLOT = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state_reg, state_next;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       result_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               cout_reg;
    logic               ovf_reg;

    logic [SLICE_W-1:0] a_slice [NSLOT];
    logic [SLICE_W-1:0] b_slice [NSLOT];
    logic [SLICE_W-1:0] core_sum;
    logic               core_cout;
    logic               accept;
    logic               last_slice;

    // Slot table padded to a power of two so idx_reg indexes it without width games.
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slice
            if (gi < WORDS) begin : g_used
                assign a_slice[gi] = a_reg[gi*SLICE_W +: SLICE_W];
                assign b_slice[gi] = b_reg[gi*SLICE_W +: SLICE_W];
            end else begin : g_pad
                assign a_slice[gi] = '0;
                assign b_slice[gi] = '0;
            end
        end
    endgenerate

    adder_seq_ctrl_adder u_adder (
        .a    (a_slice[idx_reg]),
        .b    (b_slice[idx_reg]),
        .cin  (carry_reg),
        .sum  (core_sum),
        .cout (core_cout)
    );

    assign last_slice = (idx_reg == LAST_IDX);

    always_comb begin
        state_next      = state_reg;
        io.io_in_ready  = 1'b0;
        io.io_out_valid = 1'b0;
        io.io_busy      = 1'b0;
        accept          = 1'b0;
        case (state_reg)
            IDLE: begin
                io.io_in_ready = ~reset;
                accept         = io.io_in_valid & ~reset;
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                io.io_busy = 1'b1;
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                io.io_busy      = 1'b1;
                io.io_out_valid = 1'b1;
                if (io.io_out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            idx_reg    <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B once and seed the carry.
            a_reg      <= io.io_in_a;
            b_reg      <= io.io_in_sub ? ~io.io_in_b : io.io_in_b;
            carry_reg  <= io.io_in_sub;
            idx_reg    <= '0;
            result_reg <= '0;
        end else if (state_reg == RUN) begin
            for (int w = 0; w < WORDS; w++) begin
                if (idx_reg == IDX_W'(w)) begin
                    result_reg[w*SLICE_W +: SLICE_W] <= core_sum;
                end
            end
            carry_reg <= core_cout;
            idx_reg   <= idx_reg + 1'b1;
            if (last_slice) begin
                cout_reg <= core_cout;
                ovf_reg  <= ovf_calc(a_reg[W-1], b_reg[W-1], core_sum[SLICE_W-1]);
            end
        end
    end

    assign io.io_out_sum  = result_reg;
    assign io.io_out_cout = cout_reg;
    assign io.io_out_ovf  = ovf_reg;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: directed corner cases plus random operations on a
// WORDS=4 and a WORDS=1 instance, checked against a plain-arithmetic model.
module tb_adder_seq_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    adder_seq_ctrl_if #(.WORDS(4)) bus4 ();
    adder_seq_ctrl_if #(.WORDS(1)) bus1 ();

    adder_seq_ctrl #(.WORDS(4)) dut4 (
        .clock (clk),
        .reset (rst),
        .io    (bus4.slave)
    );

    adder_seq_ctrl #(.WORDS(1)) dut1 (
        .clock (clk),
        .reset (rst),
        .io    (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Width-w add/subtract from integer arithmetic; overflow from the signed range.
    task automatic ref_model(input int w, input longint a, input longint b, input bit sub,
                             output longint sum, output bit cout, output bit ovf);
        longint m;
        longint sa;
        longint sb;
        longint sr;
        m = longint'(1) << w;
        if (sub) begin
            sum  = (a - b + m) % m;
            cout = (a >= b);
        end else begin
            sum  = (a + b) % m;
            cout = ((a + b) >= m);
        end
        sa  = (a >= m / 2) ? a - m : a;
        sb  = (b >= m / 2) ? b - m : b;
        sr  = sub ? sa - sb : sa + sb;
        ovf = (sr < -(m / 2)) || (sr >= m / 2);
    endtask

    task automatic run_op4(input logic [15:0] a, input logic [15:0] b, input bit sub, input int stall);
        longint esum;
        bit     ecout;
        bit     eovf;
        int     lat;
        ref_model(16, longint'(a), longint'(b), sub, esum, ecout, eovf);
        check("in_ready_idle", bus4.io_in_ready, 1);
        bus4.io_in_valid  = 1'b1;
        bus4.io_in_a      = a;
        bus4.io_in_b      = b;
        bus4.io_in_sub    = sub;
        bus4.io_out_ready = (stall == 0);
        @(negedge clk);
        bus4.io_in_valid = 1'b0;
        check("busy_run", bus4.io_busy, 1);
        check("in_ready_run", bus4.io_in_ready, 0);
        lat = 0;
        while (!bus4.io_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency4", lat, 4);
        check("sum4", bus4.io_out_sum, esum);
        check("cout4", bus4.io_out_cout, ecout);
        check("ovf4", bus4.io_out_ovf, eovf);
        for (int i = 0; i < stall; i++) begin
            bus4.io_in_valid = 1'b1;
            bus4.io_in_a     = 16'($urandom);
            bus4.io_in_b     = 16'($urandom);
            bus4.io_in_sub   = 1'($urandom);
            @(negedge clk);
            check("hold_valid", bus4.io_out_valid, 1);
            check("hold_sum", bus4.io_out_sum, esum);
            check("hold_cout", bus4.io_out_cout, ecout);
            check("hold_ovf", bus4.io_out_ovf, eovf);
            check("hold_in_ready", bus4.io_in_ready, 0);
        end
        bus4.io_in_valid  = 1'b0;
        bus4.io_out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_after", bus4.io_in_ready, 1);
        check("valid_after", bus4.io_out_valid, 0);
        check("sum_kept", bus4.io_out_sum, esum);
        bus4.io_out_ready = 1'b0;
        $display("w4 a=%04h b=%04h sub=%0d stall=%0d -> sum=%04h cout=%0d ovf=%0d lat=%0d",
                 a, b, sub, stall, bus4.io_out_sum, bus4.io_out_cout, bus4.io_out_ovf, lat);
    endtask

    task automatic run_op1(input logic [3:0] a, input logic [3:0] b, input bit sub);
        longint esum;
        bit     ecout;
        bit     eovf;
        int     lat;
        ref_model(4, longint'(a), longint'(b), sub, esum, ecout, eovf);
        check("in_ready_idle1", bus1.io_in_ready, 1);
        bus1.io_in_valid  = 1'b1;
        bus1.io_in_a      = a;
        bus1.io_in_b      = b;
        bus1.io_in_sub    = sub;
        bus1.io_out_ready = 1'b1;
        @(negedge clk);
        bus1.io_in_valid = 1'b0;
        lat = 0;
        while (!bus1.io_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency1", lat, 1);
        check("sum1", bus1.io_out_sum, esum);
        check("cout1", bus1.io_out_cout, ecout);
        check("ovf1", bus1.io_out_ovf, eovf);
        @(negedge clk);
        check("in_ready_after1", bus1.io_in_ready, 1);
        $display("w1 a=%01h b=%01h sub=%0d -> sum=%01h cout=%0d ovf=%0d lat=%0d",
                 a, b, sub, bus1.io_out_sum, bus1.io_out_cout, bus1.io_out_ovf, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus4.io_in_valid  = 1'b0;
        bus4.io_in_a      = '0;
        bus4.io_in_b      = '0;
        bus4.io_in_sub    = 1'b0;
        bus4.io_out_ready = 1'b0;
        bus1.io_in_valid  = 1'b0;
        bus1.io_in_a      = '0;
        bus1.io_in_b      = '0;
        bus1.io_in_sub    = 1'b0;
        bus1.io_out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", bus4.io_in_ready, 0);
        check("rst_valid", bus4.io_out_valid, 0);
        check("rst_busy", bus4.io_busy, 0);
        check("rst_sum", bus4.io_out_sum, 0);
        check("rst_cout", bus4.io_out_cout, 0);
        check("rst_ovf", bus4.io_out_ovf, 0);
        rst = 1'b0;
        #1;
        check("in_ready_post_rst", bus4.io_in_ready, 1);
        @(negedge clk);

        run_op4(16'h1234, 16'h0FFF, 1'b0, 0);
        run_op4(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op4(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op4(16'h0005, 16'h0007, 1'b1, 0);
        run_op4(16'h8000, 16'h0001, 1'b1, 0);
        run_op4(16'h4321, 16'h1111, 1'b0, 10);
        run_op4(16'h0A0A, 16'h0505, 1'b1, 0);

        // Reset in the second RUN cycle discards the operation.
        bus4.io_in_valid = 1'b1;
        bus4.io_in_a     = 16'h1111;
        bus4.io_in_b     = 16'h2222;
        bus4.io_in_sub   = 1'b0;
        @(negedge clk);
        bus4.io_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_valid", bus4.io_out_valid, 0);
        check("midrun_sum", bus4.io_out_sum, 0);
        check("midrun_busy", bus4.io_busy, 0);
        check("midrun_in_ready", bus4.io_in_ready, 0);
        rst = 1'b0;
        #1;
        run_op4(16'h00FF, 16'h0001, 1'b0, 0);

        for (int n = 0; n < 20; n++) begin
            run_op4(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        run_op1(4'hF, 4'h1, 1'b0);
        run_op1(4'h7, 4'h1, 1'b0);
        run_op1(4'h8, 4'h1, 1'b1);
        for (int n = 0; n < 10; n++) begin
            run_op1(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
